// File: rtl/fetch_packet_splitter_if.sv
// Handshake/data bundle between the fetch-queue FIFO, the splitter and the decoder.
interface fetch_packet_splitter_if #(
  parameter int FETCH_WIDTH  = 4,
  parameter int DECODE_WIDTH = 2,
  parameter int INST_WIDTH   = 32,
  parameter int PC_WIDTH     = 32
);
  logic                                 flush;
  logic                                 in_valid;
  logic                                 in_ready;
  logic [PC_WIDTH-1:0]                  in_pc;
  logic [FETCH_WIDTH*INST_WIDTH-1:0]    in_inst;
  logic [FETCH_WIDTH-1:0]               in_mask;
  logic [DECODE_WIDTH-1:0]              out_valid;
  logic                                 out_ready;
  logic [DECODE_WIDTH*INST_WIDTH-1:0]   out_inst;
  logic [DECODE_WIDTH*PC_WIDTH-1:0]     out_pc;

  // Upstream FIFO / decoder side (drives packets, flush and out_ready).
  modport master (
    output flush, in_valid, in_pc, in_inst, in_mask, out_ready,
    input  in_ready, out_valid, out_inst, out_pc
  );

  // Splitter side.
  modport slave (
    input  flush, in_valid, in_pc, in_inst, in_mask, out_ready,
    output in_ready, out_valid, out_inst, out_pc
  );
endinterface

// File: rtl/fetch_packet_splitter.sv
// Unpacks one fetch packet into compacted decode groups of up to DECODE_WIDTH
// instructions per cycle, in program order, back-pressuring the fetch FIFO
// until the held packet has drained.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | no packet held; ready for a new one
// ST_HOLD | packet held; rem has at least one slot pending
module fetch_packet_splitter #(
  parameter int FETCH_WIDTH  = 4,
  parameter int DECODE_WIDTH = 2,
  parameter int INST_WIDTH   = 32,
  parameter int PC_WIDTH     = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  fetch_packet_splitter_if.slave  bus
);

  typedef enum logic {ST_IDLE, ST_HOLD} state_t;

  state_t                                 state_q, state_d;
  logic [PC_WIDTH-1:0]                    pc_q, pc_d;
  logic [FETCH_WIDTH-1:0][INST_WIDTH-1:0] inst_q, inst_d;
  logic [FETCH_WIDTH-1:0]                 rem_q, rem_d;

  logic [FETCH_WIDTH-1:0]                 sel_mask;
  logic [DECODE_WIDTH-1:0]                lane_valid;
  logic [INST_WIDTH-1:0]                  lane_inst [DECODE_WIDTH];
  logic [PC_WIDTH-1:0]                    lane_pc   [DECODE_WIDTH];
  logic                                   fire_out;
  logic                                   fire_in;
  logic                                   last;
  logic                                   in_ready;
  int                                     rank;

  // Select the lowest pending slots of rem; the k-th pending slot feeds lane k.
  always_comb begin
    sel_mask   = '0;
    lane_valid = '0;
    rank       = 0;
    for (int k = 0; k < DECODE_WIDTH; k++) begin
      lane_inst[k] = '0;
      lane_pc[k]   = '0;
    end
    for (int s = 0; s < FETCH_WIDTH; s++) begin
      if (rem_q[s]) begin
        for (int k = 0; k < DECODE_WIDTH; k++) begin
          if (rank == k) begin
            sel_mask[s]   = 1'b1;
            lane_valid[k] = 1'b1;
            lane_inst[k]  = inst_q[s];
            lane_pc[k]    = pc_q + (PC_WIDTH'(s) << 2);
          end
        end
        rank = rank + 1;
      end
    end
  end

  // Handshake qualification; flush masks both sides for the whole cycle.
  always_comb begin
    bus.out_valid = lane_valid & {DECODE_WIDTH{(state_q == ST_HOLD) & ~bus.flush}};
    fire_out      = bus.out_ready & (|bus.out_valid);
    last          = fire_out & ~(|(rem_q & ~sel_mask));
    in_ready      = ~bus.flush & ((state_q == ST_IDLE) | last);
    fire_in       = bus.in_valid & in_ready;
    bus.in_ready  = in_ready;
  end

  for (genvar k = 0; k < DECODE_WIDTH; k++) begin : g_lane
    assign bus.out_inst[k*INST_WIDTH +: INST_WIDTH] = lane_inst[k];
    assign bus.out_pc[k*PC_WIDTH +: PC_WIDTH]       = lane_pc[k];
  end

  // Next state: flush wins, then a new accept (which may replace a draining
  // packet in the same cycle), then retirement of the issued group.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    rem_d   = rem_q;
    if (bus.flush) begin
      state_d = ST_IDLE;
      rem_d   = '0;
    end else if (fire_in) begin
      pc_d  = bus.in_pc;
      rem_d = bus.in_mask;
      for (int s = 0; s < FETCH_WIDTH; s++) begin
        inst_d[s] = bus.in_inst[s*INST_WIDTH +: INST_WIDTH];
      end
      state_d = (|bus.in_mask) ? ST_HOLD : ST_IDLE;
    end else if (fire_out) begin
      rem_d = rem_q & ~sel_mask;
      if (last) begin
        state_d = ST_IDLE;
      end
    end
  end

  // State and held-packet registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      inst_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: tb/tb_fetch_packet_splitter.sv
// Bench for fetch_packet_splitter: directed vector table, hand-written
// back-pressure / flush / async-reset sequences, then random traffic, all
// cross-checked against a queue-based model of the pending instructions.
module tb_fetch_packet_splitter;
  localparam int FW = 4;
  localparam int DW = 2;
  localparam int IW = 32;
  localparam int PW = 32;

  logic clk;
  logic rst_n;

  fetch_packet_splitter_if #(.FETCH_WIDTH(FW), .DECODE_WIDTH(DW),
                             .INST_WIDTH(IW), .PC_WIDTH(PW)) bus ();

  fetch_packet_splitter #(.FETCH_WIDTH(FW), .DECODE_WIDTH(DW),
                          .INST_WIDTH(IW), .PC_WIDTH(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } item_t;

  item_t mq[$];
  int    m_n;
  bit    m_fo, m_fi, m_fl;
  logic [31:0] m_pc;
  logic [3:0]  m_mask;
  logic [FW*IW-1:0] m_inst;

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] pc;
    logic [3:0]  mask;
    logic [31:0] ib;
    logic        ordy;
    logic [1:0]  e_ov;
    logic        e_ir;
    logic [31:0] e_pc0;
    logic [31:0] e_i0;
    logic [31:0] e_pc1;
    logic [31:0] e_i1;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lane_inst(input int k);
    return bus.out_inst[k*IW +: IW];
  endfunction

  function automatic logic [31:0] lane_pc(input int k);
    return bus.out_pc[k*PW +: PW];
  endfunction

  task automatic drive(input logic fl, input logic iv, input logic [31:0] pc,
                       input logic [3:0] mask, input logic [31:0] ib, input logic ordy);
    bus.flush     = fl;
    bus.in_valid  = iv;
    bus.in_pc     = pc;
    bus.in_mask   = mask;
    bus.out_ready = ordy;
    for (int s = 0; s < FW; s++) bus.in_inst[s*IW +: IW] = ib + 32'(s);
  endtask

  // Compare DUT against the model at mid-cycle and record the handshakes.
  task automatic sample();
    logic [1:0] e_ov;
    bit e_ir;
    @(negedge clk);
    m_fl = bus.flush;
    m_n  = bus.flush ? 0 : ((mq.size() < DW) ? mq.size() : DW);
    e_ov = (m_n == 0) ? 2'b00 : (m_n == 1) ? 2'b01 : 2'b11;
    e_ir = !bus.flush && (mq.size() == 0 || (bus.out_ready && mq.size() <= DW));
    chk("out_valid", 64'(bus.out_valid), 64'(e_ov));
    chk("in_ready", 64'(bus.in_ready), 64'(e_ir));
    for (int k = 0; k < m_n; k++) begin
      chk("lane_inst", 64'(lane_inst(k)), 64'(mq[k].inst));
      chk("lane_pc", 64'(lane_pc(k)), 64'(mq[k].pc));
    end
    m_fo   = bus.out_ready && (m_n > 0);
    m_fi   = bus.in_valid && e_ir;
    m_pc   = bus.in_pc;
    m_mask = bus.in_mask;
    m_inst = bus.in_inst;
  endtask

  task automatic advance();
    item_t it;
    @(posedge clk);
    if (m_fl) begin
      mq.delete();
    end else begin
      if (m_fo) repeat (m_n) void'(mq.pop_front());
      if (m_fi) begin
        mq.delete();
        for (int s = 0; s < FW; s++) begin
          if (m_mask[s]) begin
            it.inst = m_inst[s*IW +: IW];
            it.pc   = m_pc + 32'(4 * s);
            mq.push_back(it);
          end
        end
      end
    end
    #1;
  endtask

  initial begin
    //           fl iv pc            mask  ib      ordy  e_ov   e_ir e_pc0        e_i0      e_pc1     e_i1
    tbl[0]  = '{1'b0, 1'b1, 32'h1000, 4'hF, 32'hA0, 1'b1, 2'b00, 1'b1, 32'h0,    32'h0,  32'h0,    32'h0};
    tbl[1]  = '{1'b0, 1'b1, 32'h2000, 4'hA, 32'hB0, 1'b1, 2'b11, 1'b0, 32'h1000, 32'hA0, 32'h1004, 32'hA1};
    tbl[2]  = '{1'b0, 1'b1, 32'h2000, 4'hA, 32'hB0, 1'b1, 2'b11, 1'b1, 32'h1008, 32'hA2, 32'h100C, 32'hA3};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,    4'h0, 32'h0,  1'b1, 2'b11, 1'b1, 32'h2004, 32'hB1, 32'h200C, 32'hB3};
    tbl[4]  = '{1'b0, 1'b1, 32'h3000, 4'h0, 32'hF0, 1'b1, 2'b00, 1'b1, 32'h0,    32'h0,  32'h0,    32'h0};
    tbl[5]  = '{1'b0, 1'b1, 32'hFFFF_FFF8, 4'hC, 32'hC0, 1'b1, 2'b00, 1'b1, 32'h0, 32'h0, 32'h0,   32'h0};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,    4'h0, 32'h0,  1'b1, 2'b11, 1'b1, 32'h0,    32'hC2, 32'h4,    32'hC3};
    tbl[7]  = '{1'b0, 1'b1, 32'h4000, 4'h7, 32'hD0, 1'b1, 2'b00, 1'b1, 32'h0,    32'h0,  32'h0,    32'h0};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,    4'h0, 32'h0,  1'b1, 2'b11, 1'b0, 32'h4000, 32'hD0, 32'h4004, 32'hD1};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,    4'h0, 32'h0,  1'b1, 2'b01, 1'b1, 32'h4008, 32'hD2, 32'h0,    32'h0};
    tbl[10] = '{1'b0, 1'b0, 32'h0,    4'h0, 32'h0,  1'b1, 2'b00, 1'b1, 32'h0,    32'h0,  32'h0,    32'h0};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    #8;
    chk("reset_out_valid", 64'(bus.out_valid), 64'h0);
    chk("reset_in_ready", 64'(bus.in_ready), 64'h1);
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table: basic split with back-to-back accept, sparse mask,
    // zero mask, PC wrap, odd-count packet.
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].fl, tbl[i].iv, tbl[i].pc, tbl[i].mask, tbl[i].ib, tbl[i].ordy);
      sample();
      chk($sformatf("tbl%0d_ov", i), 64'(bus.out_valid), 64'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_ir", i), 64'(bus.in_ready), 64'(tbl[i].e_ir));
      if (tbl[i].e_ov[0]) begin
        chk($sformatf("tbl%0d_pc0", i), 64'(lane_pc(0)), 64'(tbl[i].e_pc0));
        chk($sformatf("tbl%0d_i0", i), 64'(lane_inst(0)), 64'(tbl[i].e_i0));
      end
      if (tbl[i].e_ov[1]) begin
        chk($sformatf("tbl%0d_pc1", i), 64'(lane_pc(1)), 64'(tbl[i].e_pc1));
        chk($sformatf("tbl%0d_i1", i), 64'(lane_inst(1)), 64'(tbl[i].e_i1));
      end
      advance();
    end

    // Back-pressure: group held stable, no new packet accepted.
    drive(1'b0, 1'b1, 32'h5000, 4'hF, 32'hE0, 1'b1);
    sample(); advance();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 32'h6000, 4'hF, 32'h99, 1'b0);
      sample();
      chk("bp_ov", 64'(bus.out_valid), 64'h3);
      chk("bp_ir", 64'(bus.in_ready), 64'h0);
      chk("bp_i0", 64'(lane_inst(0)), 64'hE0);
      chk("bp_pc1", 64'(lane_pc(1)), 64'h5004);
      advance();
    end
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    sample();
    chk("bp_rel_i0", 64'(lane_inst(0)), 64'hE0);
    advance();
    sample();
    chk("bp_rel2_i0", 64'(lane_inst(0)), 64'hE2);
    chk("bp_rel2_i1", 64'(lane_inst(1)), 64'hE3);
    advance();

    // Flush after the first group; remaining slots must never issue.
    drive(1'b0, 1'b1, 32'h7000, 4'hF, 32'h70, 1'b1);
    sample(); advance();
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    sample();
    chk("fl_first_i1", 64'(lane_inst(1)), 64'h71);
    advance();
    drive(1'b1, 1'b1, 32'h8000, 4'hF, 32'h80, 1'b1);
    sample();
    chk("fl_ov", 64'(bus.out_valid), 64'h0);
    chk("fl_ir", 64'(bus.in_ready), 64'h0);
    advance();
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    sample();
    chk("fl_after_ov", 64'(bus.out_valid), 64'h0);
    chk("fl_after_ir", 64'(bus.in_ready), 64'h1);
    advance();
    sample();
    chk("fl_after2_ov", 64'(bus.out_valid), 64'h0);
    advance();

    // Async reset while a packet is held.
    drive(1'b0, 1'b1, 32'h9000, 4'hF, 32'h90, 1'b0);
    sample(); advance();
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    chk("pre_rst_ov", 64'(bus.out_valid), 64'h3);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ov", 64'(bus.out_valid), 64'h0);
    chk("rst_ir", 64'(bus.in_ready), 64'h1);
    mq.delete();
    #1 rst_n = 1'b1;
    drive(1'b0, 1'b1, 32'hA000, 4'h3, 32'hA8, 1'b1);
    sample();
    chk("post_rst_ir", 64'(bus.in_ready), 64'h1);
    advance();
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    sample();
    chk("post_rst_ov", 64'(bus.out_valid), 64'h3);
    chk("post_rst_pc0", 64'(lane_pc(0)), 64'hA000);
    chk("post_rst_i1", 64'(lane_inst(1)), 64'hA9);
    advance();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bus.flush     = ($urandom_range(15) == 0);
      bus.in_valid  = $urandom_range(1);
      bus.in_pc     = $urandom;
      bus.in_mask   = 4'($urandom);
      bus.out_ready = ($urandom_range(9) < 7);
      for (int s = 0; s < FW; s++) bus.in_inst[s*IW +: IW] = $urandom;
      sample();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
